coin_acceptor: RTL and testbench

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

---
 rtl/coin_acceptor_pkg.sv | 26 ++
 rtl/coin_acceptor_sync_2ff.sv | 25 ++
 rtl/coin_acceptor.sv | 166 ++++++++++++++++
 tb/tb_coin_acceptor.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/coin_acceptor_pkg.sv
// Vending package shared by the coin acceptor and the vending FSM:
// state encodings, coin channels and default timing parameters.
package coin_acceptor_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    DEBOUNCE     = 2'd1,
    EMIT         = 2'd2,
    WAIT_RELEASE = 2'd3
  } acc_state_t;

  typedef enum logic [1:0] {
    NICKEL  = 2'd0,
    DIME    = 2'd1,
    QUARTER = 2'd2
  } coin_t;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned RELEASE_CYCLES_DEF  = 2;
  localparam logic [7:0]  COIN_COUNT_MAX      = 8'd255;

  function automatic logic [1:0] ones_count(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/coin_acceptor_sync_2ff.sv
// Two-flop synchronizer for one asynchronous coin-sensor level.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Two-stage capture of the asynchronous level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_r <= 1'b0;
      sync_r <= 1'b0;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: synchronizes and debounces three coin sensors, issues one
// qualified pulse per coin (or a reject pulse) and keeps a saturating count.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned RELEASE_CYCLES  = RELEASE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nickel_raw,
  input  logic       dime_raw,
  input  logic       quarter_raw,
  input  logic       accept_en,
  output logic       nickel_in,
  output logic       dime_in,
  output logic       quarter_in,
  output logic       coin_reject,
  output logic [7:0] coin_count
);

  localparam logic [7:0] DEB_LIMIT = 8'(DEBOUNCE_CYCLES);
  localparam logic [7:0] REL_LIMIT = 8'(RELEASE_CYCLES - 1);

  logic s_n;
  logic s_d;
  logic s_q;

  sync_2ff u_sync_n (.clk(clk), .rst(rst), .d(nickel_raw),  .q(s_n));
  sync_2ff u_sync_d (.clk(clk), .rst(rst), .d(dime_raw),    .q(s_d));
  sync_2ff u_sync_q (.clk(clk), .rst(rst), .d(quarter_raw), .q(s_q));

  acc_state_t state_r;
  coin_t      chan_r;
  logic [7:0] cnt_r;
  logic [7:0] rel_cnt_r;
  logic [7:0] coin_count_r;
  logic       nickel_in_r;
  logic       dime_in_r;
  logic       quarter_in_r;
  logic       coin_reject_r;

  logic [2:0] synced_s;
  logic [1:0] ones_s;
  logic [2:0] chan_mask_s;
  logic       others_high_s;
  logic       chan_high_s;
  coin_t      first_chan_s;

  assign synced_s = {s_q, s_d, s_n};
  assign ones_s   = ones_count(synced_s);

  // Channel decode: which sensor bit belongs to the captured coin, and which
  // channel a lone high sensor in IDLE refers to.
  always_comb begin
    chan_mask_s  = 3'b000;
    first_chan_s = NICKEL;
    case (chan_r)
      NICKEL:  chan_mask_s = 3'b001;
      DIME:    chan_mask_s = 3'b010;
      QUARTER: chan_mask_s = 3'b100;
      default: chan_mask_s = 3'b000;
    endcase
    case (synced_s)
      3'b010:  first_chan_s = DIME;
      3'b100:  first_chan_s = QUARTER;
      default: first_chan_s = NICKEL;
    endcase
  end

  assign others_high_s = |(synced_s & ~chan_mask_s);
  assign chan_high_s   = |(synced_s & chan_mask_s);

  // Acceptor FSM with registered pulse outputs and saturating coin count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      chan_r        <= NICKEL;
      cnt_r         <= 8'd0;
      rel_cnt_r     <= 8'd0;
      coin_count_r  <= 8'd0;
      nickel_in_r   <= 1'b0;
      dime_in_r     <= 1'b0;
      quarter_in_r  <= 1'b0;
      coin_reject_r <= 1'b0;
    end else begin
      nickel_in_r   <= 1'b0;
      dime_in_r     <= 1'b0;
      quarter_in_r  <= 1'b0;
      coin_reject_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ones_s == 2'd1) begin
            chan_r  <= first_chan_s;
            cnt_r   <= 8'd1;
            state_r <= DEBOUNCE;
          end else if (ones_s >= 2'd2) begin
            coin_reject_r <= 1'b1;
            rel_cnt_r     <= 8'd0;
            state_r       <= WAIT_RELEASE;
          end else begin
            state_r <= IDLE;
          end
        end
        DEBOUNCE: begin
          // A second coin during debounce wins over a dropout: return both.
          if (others_high_s) begin
            coin_reject_r <= 1'b1;
            cnt_r         <= 8'd0;
            rel_cnt_r     <= 8'd0;
            state_r       <= WAIT_RELEASE;
          end else if (!chan_high_s) begin
            cnt_r   <= 8'd0;
            state_r <= IDLE;
          end else if (cnt_r == DEB_LIMIT) begin
            state_r <= EMIT;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        EMIT: begin
          if (accept_en) begin
            case (chan_r)
              NICKEL:  nickel_in_r   <= 1'b1;
              DIME:    dime_in_r     <= 1'b1;
              QUARTER: quarter_in_r  <= 1'b1;
              default: coin_reject_r <= 1'b1;
            endcase
            if (coin_count_r != COIN_COUNT_MAX) begin
              coin_count_r <= coin_count_r + 8'd1;
            end else begin
              coin_count_r <= coin_count_r;
            end
          end else begin
            coin_reject_r <= 1'b1;
          end
          cnt_r     <= 8'd0;
          rel_cnt_r <= 8'd0;
          state_r   <= WAIT_RELEASE;
        end
        WAIT_RELEASE: begin
          if (|synced_s) begin
            rel_cnt_r <= 8'd0;
          end else if (rel_cnt_r == REL_LIMIT) begin
            rel_cnt_r <= 8'd0;
            state_r   <= IDLE;
          end else begin
            rel_cnt_r <= rel_cnt_r + 8'd1;
          end
        end
        default: begin
          cnt_r     <= 8'd0;
          rel_cnt_r <= 8'd0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

  assign nickel_in   = nickel_in_r;
  assign dime_in     = dime_in_r;
  assign quarter_in  = quarter_in_r;
  assign coin_reject = coin_reject_r;
  assign coin_count  = coin_count_r;

endmodule

// File: tb/tb_coin_acceptor.sv
// Self-checking bench for coin_acceptor: directed scenarios plus randomized
// coin episodes compared cycle by cycle against a behavioural model.
module tb_coin_acceptor;

  localparam int D = 4;
  localparam int R = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       nickel_raw, dime_raw, quarter_raw, accept_en;
  logic       nickel_in, dime_in, quarter_in, coin_reject;
  logic [7:0] coin_count;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .RELEASE_CYCLES(R)) dut (
    .clk(clk), .rst(rst),
    .nickel_raw(nickel_raw), .dime_raw(dime_raw), .quarter_raw(quarter_raw),
    .accept_en(accept_en),
    .nickel_in(nickel_in), .dime_in(dime_in), .quarter_in(quarter_in),
    .coin_reject(coin_reject), .coin_count(coin_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural model: a coin is paid out when one sensor is seen alone for
  // D+1 consecutive synced samples while armed; the acceptor re-arms after R
  // consecutive quiet samples.
  logic [2:0] m_s1, m_s2;
  bit         armed, emit_due;
  int         held, ch, quiet, m_count;
  logic [2:0] exp_in;
  bit         exp_rej;

  task automatic model_edge(input logic [2:0] raw, input logic ae, input logic r);
    logic [2:0] sv, mine;
    int pc;
    exp_in  = 3'b000;
    exp_rej = 1'b0;
    if (r) begin
      armed = 1; held = 0; emit_due = 0; quiet = 0; m_count = 0;
      m_s1 = 3'b000; m_s2 = 3'b000;
    end else begin
      sv = m_s2;
      pc = $countones(sv);
      mine = 3'b001 << ch;
      if (emit_due) begin
        emit_due = 0;
        quiet = 0;
        if (ae) begin
          exp_in = mine;
          if (m_count < 255) m_count++;
        end else exp_rej = 1;
      end else if (!armed) begin
        if (sv != 3'b000) quiet = 0; else quiet++;
        if (quiet == R) begin armed = 1; quiet = 0; end
      end else if (held == 0) begin
        if (pc >= 2) begin exp_rej = 1; armed = 0; quiet = 0; end
        else if (pc == 1) begin
          for (int i = 0; i < 3; i++) if (sv[i]) ch = i;
          held = 1;
        end
      end else begin
        if ((sv & ~mine) != 3'b000) begin exp_rej = 1; armed = 0; held = 0; quiet = 0; end
        else if (sv == 3'b000) held = 0;
        else if (held == D) begin emit_due = 1; armed = 0; held = 0; end
        else held++;
      end
      m_s2 = m_s1;
      m_s1 = raw;
    end
  endtask

  int nn, nd, nq, nr;

  // raw bit 0 = nickel, bit 1 = dime, bit 2 = quarter
  task automatic step(input logic [2:0] raw, input logic ae, input logic r);
    logic [31:0] obs, exp;
    @(negedge clk);
    nickel_raw = raw[0]; dime_raw = raw[1]; quarter_raw = raw[2];
    accept_en = ae; rst = r;
    model_edge(raw, ae, r);
    @(posedge clk);
    #1;
    obs = {20'd0, nickel_in, dime_in, quarter_in, coin_reject, coin_count};
    exp = {20'd0, exp_in[0], exp_in[1], exp_in[2], exp_rej, 8'(m_count)};
    check("cycle", obs, exp);
    nn += int'(nickel_in); nd += int'(dime_in); nq += int'(quarter_in); nr += int'(coin_reject);
  endtask

  task automatic clear_counts();
    nn = 0; nd = 0; nq = 0; nr = 0;
  endtask

  task automatic do_reset();
    step(3'b000, 1'b0, 1'b1);
    step(3'b000, 1'b0, 1'b1);
  endtask

  initial begin
    int first;
    logic [2:0] v;
    rst = 1'b1; nickel_raw = 1'b0; dime_raw = 1'b0; quarter_raw = 1'b0; accept_en = 1'b0;
    ch = 0;
    model_edge(3'b000, 1'b0, 1'b1);
    clear_counts();

    do_reset();
    check("reset_outputs", {nickel_in, dime_in, quarter_in, coin_reject, coin_count}, 12'd0);

    // Clean dime, accepted
    clear_counts(); first = -1;
    for (int i = 0; i < 20; i++) begin
      step(3'b010, 1'b1, 1'b0);
      if (dime_in && first < 0) first = i;
    end
    repeat (4) step(3'b000, 1'b1, 1'b0);
    check("dime_latency", first, 3 + D);
    check("dime_pulses", nd, 1);
    check("dime_other", nn + nq + nr, 0);
    check("dime_count", coin_count, 1);

    // Simultaneous nickel + quarter is rejected, count unchanged
    clear_counts();
    repeat (6) step(3'b101, 1'b1, 1'b0);
    repeat (6) step(3'b000, 1'b1, 1'b0);
    check("double_reject", nr, 1);
    check("double_no_in", nn + nd + nq, 0);
    check("double_count", coin_count, 1);

    // Short nickel glitches are discarded, acceptor stays idle
    do_reset(); clear_counts();
    step(3'b001, 1'b1, 1'b0); step(3'b001, 1'b1, 1'b0);
    step(3'b000, 1'b1, 1'b0);
    step(3'b001, 1'b1, 1'b0); step(3'b001, 1'b1, 1'b0);
    repeat (10) step(3'b000, 1'b1, 1'b0);
    check("glitch_pulses", nn + nd + nq + nr, 0);
    check("glitch_count", coin_count, 0);
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step(3'b010, 1'b1, 1'b0);
      if (dime_in && first < 0) first = i;
    end
    check("glitch_idle_latency", first, 3 + D);

    // Quarter with accept_en low is returned
    do_reset(); clear_counts(); first = -1;
    for (int i = 0; i < 15; i++) begin
      step(3'b100, 1'b0, 1'b0);
      if (coin_reject && first < 0) first = i;
    end
    repeat (4) step(3'b000, 1'b0, 1'b0);
    check("noaccept_latency", first, 3 + D);
    check("noaccept_reject", nr, 1);
    check("noaccept_quarter", nq, 0);
    check("noaccept_count", coin_count, 0);

    // Reset during EMIT suppresses the pulse; held coin is then a new coin
    do_reset(); clear_counts();
    for (int i = 0; i < 3 + D; i++) step(3'b100, 1'b1, 1'b0);
    step(3'b100, 1'b1, 1'b1);
    check("emit_reset_outputs", {nickel_in, dime_in, quarter_in, coin_reject, coin_count}, 12'd0);
    check("emit_reset_pulses", nn + nd + nq + nr, 0);
    first = -1;
    for (int i = 0; i < 12; i++) begin
      step(3'b100, 1'b1, 1'b0);
      if (quarter_in && first < 0) first = i;
    end
    repeat (4) step(3'b000, 1'b1, 1'b0);
    check("post_reset_latency", first, 3 + D);
    check("post_reset_quarter", nq, 1);

    // 260 nickels: count saturates, pulses keep coming
    do_reset(); clear_counts();
    for (int k = 0; k < 260; k++) begin
      repeat (8) step(3'b001, 1'b1, 1'b0);
      repeat (4) step(3'b000, 1'b1, 1'b0);
    end
    check("sat_pulses", nn, 260);
    check("sat_count", coin_count, 255);

    // Randomized coin episodes
    do_reset();
    for (int e = 0; e < 300; e++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: begin
          v = 3'b001 << $urandom_range(0, 2);
          repeat ($urandom_range(1, 12)) step(v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
          repeat ($urandom_range(1, 5)) step(3'b000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
        end
        3: begin
          v = 3'($urandom_range(3, 7));
          if ($countones(v) < 2) v = 3'b110;
          repeat ($urandom_range(1, 8)) step(v, 1'($urandom_range(0, 1)), 1'b0);
          repeat ($urandom_range(1, 5)) step(3'b000, 1'($urandom_range(0, 1)), 1'b0);
        end
        4: begin
          repeat ($urandom_range(1, 10)) step(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 99) == 0));
        end
        default: begin
          v = 3'b001 << $urandom_range(0, 2);
          repeat ($urandom_range(1, 6)) step(v, 1'b1, 1'b0);
          v = v | (3'b001 << $urandom_range(0, 2));
          repeat ($urandom_range(1, 4)) step(v, 1'b1, 1'b0);
          repeat ($urandom_range(2, 5)) step(3'b000, 1'b1, 1'b0);
        end
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
